sim_ctrl_monitor: RTL
=====================

# sim_ctrl_monitor

Passive, synthesizable simulation-control monitor that snoops the CPU data-bus write port and decodes a small bank of control registers at a parametrised base address. Generalises the single-address done-write detector to a console output FIFO, a programmable watchdog, pass/fail exit codes and a drain-then-finish sequence. Instantiated beside `cpu0` inside `top`; the testbench only watches `finish_o`.

## Interface
Parameters:
- `BASE_ADDR`, 32'h80F6_00C0: register bank base. Word-aligned offsets: CONSOLE +0x00, HEARTBEAT +0x04, TIMEOUT +0x08, DONE +0x10.
- `DONE_MAGIC`, 32'h0000_DEAD: pass value written to DONE.
- `CON_DEPTH`, 16: console FIFO depth; power of 2, at least 2.
- `WDOG_W`, 32: watchdog counter width.
- `WDOG_DEFAULT`, 0: TIMEOUT reset value; 0 means disabled.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: async active-low reset.
- `data_req_i` in 1: snooped CPU request.
- `data_gnt_i` in 1: snooped grant.
- `data_we_i` in 1: snooped write enable.
- `data_be_i` in 4: snooped byte enables.
- `data_addr_i` in 32: snooped address.
- `data_wdata_i` in 32: snooped write data.
- `con_valid_o` out 1: console byte available.
- `con_data_o` out 8: console byte at FIFO head.
- `con_ready_i` in 1: consumer pops the head byte.
- `con_overflow_o` out 1: sticky; a console byte was dropped.
- `done_o` out 1: sticky; run ended.
- `pass_o` out 1: valid while `done_o`=1.
- `timeout_o` out 1: sticky; the watchdog expired.
- `exit_code_o` out 16: final code.
- `finish_o` out 1: sticky; done and console drained.

## Operation
- Write strobe `wr = data_req_i & data_gnt_i & data_we_i`. Decode compares the full 32-bit address. Non-matching addresses are ignored.
- CONSOLE: requires `wr` and `data_be_i[0]`. Pushes `data_wdata_i[7:0]`. When full with no pop in the same cycle, the byte is dropped and `con_overflow_o` is set.
- HEARTBEAT: any byte enable. Reloads the watchdog counter from the TIMEOUT register.
- TIMEOUT: requires `data_be_i`=4'hF. Writes TIMEOUT and reloads the counter with `data_wdata_i[WDOG_W-1:0]`. Writing 0 disables the watchdog.
- DONE: requires `data_be_i`=4'hF.
  - wdata == `DONE_MAGIC`: pass, exit code 0.
  - `wdata[31:16]` == 16'hFA11: fail, exit code = `wdata[15:0]`.
  - Any other value is ignored.
- Watchdog: while in RUN with counter ≠ 0, the counter decrements by 1 each cycle. The 1→0 transition ends the run: fail, `timeout_o`=1, exit code 16'hFFFF.
- FSM states: RUN, DRAIN, HALT.
  - RUN→DRAIN on a DONE decode or watchdog expiry. `done_o`, `pass_o` and `exit_code_o` are latched on the same edge.
  - DRAIN→HALT when the FIFO is empty. `finish_o` is set on entry to HALT.
  - HALT is terminal until reset.
- In DRAIN and HALT, all register writes are ignored and the watchdog is frozen. The FIFO continues to pop.
- Precedence: a DONE decode and watchdog expiry in the same cycle resolve to the DONE decode, and `timeout_o` stays 0. Only the first terminating event is latched.

## Timing
- Reset values: `con_valid_o`=0, `con_data_o`=0, `con_overflow_o`=0, `done_o`=0, `pass_o`=0, `timeout_o`=0, `exit_code_o`=0, `finish_o`=0. State is RUN, the FIFO is empty, and the counter and TIMEOUT register equal `WDOG_DEFAULT`.
- Bus capture happens on the edge where `wr`=1. Register effects are visible in the following cycle (latency 1).
- Console push at edge N: `con_valid_o`=1 from cycle N+1. A pop occurs at an edge where `con_valid_o & con_ready_i`. `con_data_o` is the registered head and is held while not popped.
- Full FIFO with simultaneous push and pop: both happen and the occupancy is unchanged.
- Empty FIFO: `con_ready_i` has no effect.
- FIFO pointers wrap modulo `CON_DEPTH`. An extra occupancy bit distinguishes full from empty.
- DONE at edge N with an empty FIFO: DRAIN in cycle N+1, HALT and `finish_o` from N+2.
- Watchdog programmed to T at edge N with no further writes: expiry edge at N+T, so `done_o`=1 in cycle N+T+1.
- Reset asserted mid-run clears everything asynchronously, including FIFO contents and sticky flags.

## Structure
- Package `sim_ctrl_pkg` holds:
  - register offset constants;
  - the fail tag 16'hFA11;
  - the timeout code 16'hFFFF;
  - the `sim_state_e` enum {RUN, DRAIN, HALT}.
- One sub-module, `sim_ctrl_fifo`: parametrised width/depth synchronous FIFO with registered head and full/empty outputs. The decode, watchdog and FSM stay in `sim_ctrl_monitor`.

## Test plan
- DONE write 32'h0000_DEAD with be=F at 0x80F6_00D0, FIFO empty → `done_o`=1, `pass_o`=1, `exit_code_o`=0 next cycle; `finish_o`=1 two cycles after the write.
- Write 32'hFA11_0042 to DONE → `pass_o`=0, `exit_code_o`=16'h0042. A following 32'h0000_DEAD write is ignored.
- Write "OK\n" to CONSOLE with `con_ready_i`=0, then DONE → state stays in DRAIN. Raise `con_ready_i` → the bytes 8'h4F, 8'h4B, 8'h0A are popped in order, then `finish_o`=1.
- Push 17 bytes with `CON_DEPTH`=16 and no pops → the 17th is dropped and `con_overflow_o`=1. Push and pop in the same cycle while full → occupancy stays 16.
- Write TIMEOUT=20 with no heartbeat → `timeout_o`=1, `exit_code_o`=16'hFFFF 21 cycles later. With heartbeats every 10 cycles → no timeout. A DONE write on the expiry cycle → pass, `timeout_o`=0.
- Assert `rst_ni` low during DRAIN → all outputs return to 0 immediately. After release, the block runs normally.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared constants and state type for the simulation-control monitor.
package sim_ctrl_pkg;

    localparam logic [31:0] OFF_CONSOLE   = 32'h0000_0000;
    localparam logic [31:0] OFF_HEARTBEAT = 32'h0000_0004;
    localparam logic [31:0] OFF_TIMEOUT   = 32'h0000_0008;
    localparam logic [31:0] OFF_DONE      = 32'h0000_0010;

    localparam logic [15:0] FAIL_TAG     = 16'hFA11;
    localparam logic [15:0] TIMEOUT_CODE = 16'hFFFF;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } sim_state_e;

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Synchronous FIFO with a registered head word and full/empty flags.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sim_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wrPtr;
    logic [PW:0]      r_rdPtr;
    logic [WIDTH-1:0] r_head;
    logic [PW:0]      w_count;
    logic [PW:0]      w_rdNext;
    logic             w_doPop;
    logic             w_doPush;
    logic             w_oneLeft;

    assign o_empty   = (r_wrPtr == r_rdPtr);
    assign o_full    = (r_wrPtr[PW] != r_rdPtr[PW]) &&
                       (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
    assign w_count   = r_wrPtr - r_rdPtr;
    assign w_rdNext  = r_rdPtr + (PW+1)'(1);
    assign w_oneLeft = (w_count == (PW+1)'(1));
    assign w_doPop   = i_pop & ~o_empty;
    assign w_doPush  = i_push & (~o_full | w_doPop);
    assign o_head    = r_head;

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[PW-1:0]] <= i_data;
        end
    end

    // Pointer advance and head register: the head is refilled from the array on a
    // pop, or straight from the push data when the FIFO is (or becomes) empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_head  <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + (PW+1)'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= w_rdNext;
            end
            if (w_doPush && (o_empty || (w_doPop && w_oneLeft))) begin
                r_head <= i_data;
            end else if (w_doPop && !w_oneLeft) begin
                r_head <= r_mem[w_rdNext[PW-1:0]];
            end
        end
    end

endmodule

// File: rtl/sim_ctrl_monitor.sv
// Passive monitor that snoops CPU bus writes to a small control-register bank:
// console FIFO, watchdog, pass/fail exit code and a drain-then-finish sequence.
module sim_ctrl_monitor
    import sim_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h80F6_00C0,
    parameter logic [31:0] DONE_MAGIC   = 32'h0000_DEAD,
    parameter int          CON_DEPTH    = 16,
    parameter int          WDOG_W       = 32,
    parameter logic [WDOG_W-1:0] WDOG_DEFAULT = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_gnt_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        con_overflow_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] exit_code_o,
    output logic        finish_o
);
    sim_state_e        r_state;
    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] r_timeout;
    logic              r_overflow;
    logic              r_done;
    logic              r_pass;
    logic              r_timedOut;
    logic [15:0]       r_exitCode;
    logic              r_finish;

    logic w_wr;
    logic w_running;
    logic w_hitCon;
    logic w_hitHb;
    logic w_hitTo;
    logic w_isPass;
    logic w_isFail;
    logic w_hitDone;
    logic w_expire;
    logic w_fifoFull;
    logic w_fifoEmpty;

    assign w_wr      = data_req_i & data_gnt_i & data_we_i;
    assign w_running = (r_state == RUN);
    assign w_hitCon  = w_running & w_wr & data_be_i[0] &
                       (data_addr_i == BASE_ADDR + OFF_CONSOLE);
    assign w_hitHb   = w_running & w_wr & (|data_be_i) &
                       (data_addr_i == BASE_ADDR + OFF_HEARTBEAT);
    assign w_hitTo   = w_running & w_wr & (data_be_i == 4'hF) &
                       (data_addr_i == BASE_ADDR + OFF_TIMEOUT);
    assign w_isPass  = (data_wdata_i == DONE_MAGIC);
    assign w_isFail  = (data_wdata_i[31:16] == FAIL_TAG);
    assign w_hitDone = w_running & w_wr & (data_be_i == 4'hF) &
                       (data_addr_i == BASE_ADDR + OFF_DONE) & (w_isPass | w_isFail);
    assign w_expire  = w_running & (r_wdog == WDOG_W'(1)) & ~w_hitHb & ~w_hitTo;

    sim_ctrl_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_hitCon),
        .i_data  (data_wdata_i[7:0]),
        .i_pop   (con_ready_i),
        .o_head  (con_data_o),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    assign con_valid_o    = ~w_fifoEmpty;
    assign con_overflow_o = r_overflow;
    assign done_o         = r_done;
    assign pass_o         = r_pass;
    assign timeout_o      = r_timedOut;
    assign exit_code_o    = r_exitCode;
    assign finish_o       = r_finish;

    // Watchdog: reload on TIMEOUT or HEARTBEAT writes, otherwise count down; frozen once the run ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog    <= WDOG_DEFAULT;
            r_timeout <= WDOG_DEFAULT;
        end else if (w_running) begin
            if (w_hitTo) begin
                r_wdog    <= data_wdata_i[WDOG_W-1:0];
                r_timeout <= data_wdata_i[WDOG_W-1:0];
            end else if (w_hitHb) begin
                r_wdog <= r_timeout;
            end else if (r_wdog != '0) begin
                r_wdog <= r_wdog - WDOG_W'(1);
            end
        end
    end

    // Sticky overflow flag: a console byte arrived while full with no pop to make room.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (w_hitCon && w_fifoFull && !con_ready_i) begin
            r_overflow <= 1'b1;
        end
    end

    // Run-control FSM: latch the first terminating event, wait for the console to drain, then finish.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= RUN;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timedOut <= 1'b0;
            r_exitCode <= '0;
            r_finish   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hitDone) begin
                        r_state    <= DRAIN;
                        r_done     <= 1'b1;
                        r_pass     <= w_isPass;
                        r_exitCode <= w_isPass ? 16'h0000 : data_wdata_i[15:0];
                    end else if (w_expire) begin
                        r_state    <= DRAIN;
                        r_done     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_timedOut <= 1'b1;
                        r_exitCode <= TIMEOUT_CODE;
                    end
                end
                DRAIN: begin
                    if (w_fifoEmpty) begin
                        r_state  <= HALT;
                        r_finish <= 1'b1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

endmodule
